hazard_ctrl: RTL and testbench

Pipeline hazard controller for the e5rv32 five-stage core. It reads destination and write-enable information coming back from the E, M and W stages and drives forwarding selects, stalls and flushes into the F/D/E/M pipeline registers. It owns the post-reset startup flush sequence. It tracks data-memory wait cycles with a small state machine, and flags memory timeouts. It is clocked on the falling edge, like the pipeline registers it controls.

---
 rtl/e5rv32_pkg.sv | 40 ++++
 rtl/fwd_sel.sv | 30 +++
 rtl/hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e5rv32_pkg.sv
// Shared types and encodings for the e5rv32 pipeline control logic.
package e5rv32_pkg;

  // Operand source select for the E stage ALU inputs.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // value read from the register file in D
    FWD_W  = 2'b01,  // result being written back from W
    FWD_M  = 2'b10   // ALU result sitting in M
  } fwd_sel_e;

  // ResultSrc encodings carried down the pipe with each instruction.
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // Hazard controller sequencing states.
  typedef enum logic [1:0] {
    HZ_INIT    = 2'b00,  // post-reset front-end flush
    HZ_RUN     = 2'b01,  // normal operation
    HZ_MEMWAIT = 2'b10   // data memory is holding the pipe
  } hz_state_e;

  // Bundle of hold/bubble controls into the pipeline registers.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctl_t;

  // A later stage produces a register the reader needs; x0 never counts
  // because it is hardwired to zero and never truly written.
  function automatic logic dest_hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one E-stage source operand.
// The M stage holds the younger result, so it wins over W.
module fwd_sel
  import e5rv32_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output fwd_sel_e   fwd_sel_o
);

  logic hit_m;
  logic hit_w;

  assign hit_m = RegWriteM && dest_hit(RdM, RsE);
  assign hit_w = RegWriteW && dest_hit(RdW, RsE);

  // Priority pick: M result, then W result, then register file.
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (hit_m) begin
      fwd_sel_o = FWD_M;
    end else if (hit_w) begin
      fwd_sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the e5rv32 five-stage core.
// State lives on the falling clock edge, matching the pipeline registers.
// Stall/flush/forward outputs are combinational from state and inputs.
module hazard_ctrl
  import e5rv32_pkg::*;
#(
  parameter int STARTUP_CYCLES = 1,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic [1:0] ResultSrcE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCSrcE,
  input  logic       DMemReqM,
  input  logic       DMemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemTimeout,
  output hz_state_e  state_dbg
);

  localparam int SW = $clog2(STARTUP_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  // Last startup count value before leaving INIT.
  localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYCLES - 1);
  // Wait count at which the memory is declared stuck.
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MEM_TIMEOUT);

  hz_state_e     state_q, state_d;
  logic [SW-1:0] start_cnt_q, start_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_timeout_q, mem_timeout_d;

  logic          mem_stall;
  logic          lw_stall;
  hz_ctl_t       ctl;
  fwd_sel_e      fwd_a;
  fwd_sel_e      fwd_b;

  // Data memory has an access in M that is not finishing this cycle.
  assign mem_stall = DMemReqM && !DMemReadyM;

  // A load in E feeds an instruction in D; that value is not ready yet.
  assign lw_stall  = (ResultSrcE == RES_LOAD) &&
                     (dest_hit(RdE, Rs1D) || dest_hit(RdE, Rs2D));

  fwd_sel u_fwd_a (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd_sel_o (fwd_a)
  );

  fwd_sel u_fwd_b (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd_sel_o (fwd_b)
  );

  // Forwarding is live in every state but parks at the register file in reset.
  assign ForwardAE = reset ? fwd_a : FWD_RF;
  assign ForwardBE = reset ? fwd_b : FWD_RF;

  // State, counters and sticky timeout flag, all cleared by reset.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= HZ_INIT;
      start_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_cnt_q   <= start_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next-state logic: startup count, memory wait tracking and timeout.
  always_comb begin
    state_d       = state_q;
    start_cnt_d   = start_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    unique case (state_q)
      HZ_INIT: begin
        if (start_cnt_q == START_LAST) begin
          state_d     = HZ_RUN;
          start_cnt_d = '0;
        end else begin
          start_cnt_d = start_cnt_q + SW'(1);
        end
      end

      HZ_RUN: begin
        if (mem_stall) begin
          // This edge completes the first wait cycle.
          state_d    = HZ_MEMWAIT;
          wait_cnt_d = WW'(1);
          if (WAIT_MAX == WW'(1)) begin
            mem_timeout_d = 1'b1;
          end
        end
      end

      HZ_MEMWAIT: begin
        if (mem_stall) begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
          if (wait_cnt_d == WAIT_MAX) begin
            mem_timeout_d = 1'b1;
          end
        end else begin
          state_d    = HZ_RUN;
          wait_cnt_d = '0;
        end
      end

      default: begin
        state_d     = HZ_INIT;
        start_cnt_d = '0;
        wait_cnt_d  = '0;
      end
    endcase
  end

  // Stall/flush outputs with priority INIT > memory wait > branch > load-use.
  always_comb begin
    ctl = '0;
    if (state_q == HZ_INIT) begin
      ctl.stall_f = 1'b1;
      ctl.flush_d = 1'b1;
      ctl.flush_e = 1'b1;
    end else if (mem_stall) begin
      // Freeze F..M; W gets a bubble so the stalled load is not retired twice.
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.stall_m = 1'b1;
      ctl.flush_w = 1'b1;
    end else if (PCSrcE) begin
      // The D instruction is squashed, so a load-use stall on it is moot.
      ctl.flush_d = 1'b1;
      ctl.flush_e = 1'b1;
    end else if (lw_stall) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.flush_e = 1'b1;
    end
  end

  assign StallF     = ctl.stall_f;
  assign StallD     = ctl.stall_d;
  assign StallE     = ctl.stall_e;
  assign StallM     = ctl.stall_m;
  assign FlushD     = ctl.flush_d;
  assign FlushE     = ctl.flush_e;
  assign FlushW     = ctl.flush_w;
  assign MemTimeout = mem_timeout_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic,
// checked against a cycle-count model of the controller's rules.
module tb_hazard_ctrl;
  import e5rv32_pkg::*;

  localparam int STARTUP = 2;
  localparam int MT      = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, DMemReqM, DMemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic       MemTimeout;
  hz_state_e  state_dbg;
  logic [6:0] obs_ctl;

  int checks = 0;
  int errors = 0;

  // Model: edges of INIT still to go, consecutive wait cycles, sticky flag.
  int m_init_left;
  int m_wait_cnt;
  bit m_timeout;

  hazard_ctrl #(.STARTUP_CYCLES(STARTUP), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .state_dbg(state_dbg)
  );

  assign obs_ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  // ---------------- reference model ----------------
  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (!reset) return 2'b00;
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [6:0] m_ctl();
    bit mem;
    bit lw;
    mem = DMemReqM && !DMemReadyM;
    lw  = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    if (!reset || m_init_left > 0) return 7'b1000110;
    if (mem)    return 7'b1111001;
    if (PCSrcE) return 7'b0000110;
    if (lw)     return 7'b1100010;
    return 7'b0000000;
  endfunction

  function automatic hz_state_e m_state();
    if (!reset || m_init_left > 0) return HZ_INIT;
    if (m_wait_cnt > 0) return HZ_MEMWAIT;
    return HZ_RUN;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    DMemReqM = 0; DMemReadyM = 0;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    m_init_left = STARTUP;
    m_wait_cnt  = 0;
    m_timeout   = 0;
  endtask

  // Advance one falling edge, update the model, return at the drive point.
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      if (m_init_left > 0) m_init_left--;
      else if (DMemReqM && !DMemReadyM) begin
        if (m_wait_cnt < MT) m_wait_cnt++;
        if (m_wait_cnt == MT) m_timeout = 1;
      end else m_wait_cnt = 0;
    end
    #2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    assert_reset();
    Rs1E = 5; RdM = 5; RegWriteM = 1; Rs2E = 6; RdW = 6; RegWriteW = 1;
    DMemReqM = 1; PCSrcE = 1;
    #3;
    checks++;
    if (obs_ctl !== 7'b1000110) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", obs_ctl, 7'b1000110);
    end
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd: got %b want 0000", {ForwardAE, ForwardBE});
    end
    checks++;
    if (MemTimeout !== 1'b0 || state_dbg !== HZ_INIT) begin
      errors++; $display("FAIL reset_state: got to=%b st=%0d want to=0 st=%0d", MemTimeout, state_dbg, HZ_INIT);
    end
    tick();
    tick();
  endtask

  task automatic test_startup(input string tag);
    idle_inputs();
    reset = 1'b1;
    for (int e = 0; e <= STARTUP; e++) begin
      #1;
      checks++;
      if (obs_ctl !== ((e < STARTUP) ? 7'b1000110 : 7'b0000000)) begin
        errors++; $display("FAIL %s_edge%0d: got %b want %b", tag, e, obs_ctl,
                           (e < STARTUP) ? 7'b1000110 : 7'b0000000);
      end
      checks++;
      if (state_dbg !== m_state()) begin
        errors++; $display("FAIL %s_state%0d: got %0d want %0d", tag, e, state_dbg, m_state());
      end
      if (e < STARTUP) tick(); else #1;
    end
    tick();
  endtask

  task automatic test_forwarding();
    idle_inputs();
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    #1;
    checks++;
    if (ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_m_prio: got %b want 10", ForwardAE);
    end
    RdM = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_w: got %b want 01", ForwardAE);
    end
    Rs2E = 0; RdW = 0;
    #1;
    checks++;
    if (ForwardBE !== 2'b00) begin
      errors++; $display("FAIL fwd_x0: got %b want 00", ForwardBE);
    end
    tick();
    for (int i = 0; i < 40; i++) begin
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdM  = 5'($urandom_range(0, 3)); RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      #1;
      checks++;
      if ({ForwardAE, ForwardBE} !== {m_fwd(Rs1E), m_fwd(Rs2E)}) begin
        errors++; $display("FAIL fwd_rand%0d: got %b want %b", i, {ForwardAE, ForwardBE},
                           {m_fwd(Rs1E), m_fwd(Rs2E)});
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; Rs1D = 3;
    #1;
    checks++;
    if (obs_ctl !== 7'b1100010) begin
      errors++; $display("FAIL load_use: got %b want %b", obs_ctl, 7'b1100010);
    end
    PCSrcE = 1;
    #1;
    checks++;
    if (obs_ctl !== 7'b0000110) begin
      errors++; $display("FAIL load_use_branch: got %b want %b", obs_ctl, 7'b0000110);
    end
    PCSrcE = 0; RdE = 0; Rs2D = 0;
    #1;
    checks++;
    if (obs_ctl !== 7'b0000000) begin
      errors++; $display("FAIL load_x0: got %b want 0000000", obs_ctl);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    idle_inputs();
    ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
    DMemReqM = 1; DMemReadyM = 0; PCSrcE = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (obs_ctl !== 7'b1111001) begin
        errors++; $display("FAIL memwait_c%0d: got %b want %b", c, obs_ctl, 7'b1111001);
      end
      checks++;
      if (state_dbg !== ((c == 0) ? HZ_RUN : HZ_MEMWAIT)) begin
        errors++; $display("FAIL memwait_st%0d: got %0d want %0d", c, state_dbg, m_state());
      end
      tick();
    end
    DMemReadyM = 1;
    #1;
    checks++;
    if (obs_ctl !== 7'b0000110) begin
      errors++; $display("FAIL memwait_ready: got %b want %b", obs_ctl, 7'b0000110);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (state_dbg !== HZ_RUN || MemTimeout !== 1'b0) begin
      errors++; $display("FAIL memwait_exit: got st=%0d to=%b want st=%0d to=0", state_dbg, MemTimeout, HZ_RUN);
    end
    tick();
  endtask

  task automatic test_timeout();
    idle_inputs();
    DMemReqM = 1; DMemReadyM = 0;
    for (int c = 1; c <= MT + 1; c++) begin
      tick();
      #1;
      checks++;
      if (MemTimeout !== ((c >= MT) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL timeout_c%0d: got %b want %b", c, MemTimeout, (c >= MT));
      end
    end
    DMemReadyM = 1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (MemTimeout !== 1'b1 || state_dbg !== HZ_RUN || obs_ctl !== 7'b0000000) begin
      errors++; $display("FAIL timeout_sticky: got to=%b st=%0d ctl=%b want to=1 st=%0d ctl=0000000",
                         MemTimeout, state_dbg, obs_ctl, HZ_RUN);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    DMemReqM = 1; DMemReadyM = 0;
    tick();
    Rs1E = 9; RdM = 9; RegWriteM = 1;
    assert_reset();
    #1;
    checks++;
    if (obs_ctl !== 7'b1000110 || ForwardAE !== 2'b00) begin
      errors++; $display("FAIL midwait_reset: got ctl=%b fa=%b want ctl=1000110 fa=00", obs_ctl, ForwardAE);
    end
    checks++;
    if (MemTimeout !== 1'b0 || state_dbg !== HZ_INIT) begin
      errors++; $display("FAIL midwait_clear: got to=%b st=%0d want to=0 st=%0d", MemTimeout, state_dbg, HZ_INIT);
    end
    tick();
    test_startup("restart");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 2));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      PCSrcE = ($urandom_range(0, 3) == 0);
      DMemReqM = 1'($urandom);
      DMemReadyM = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (obs_ctl !== m_ctl()) begin
        errors++; $display("FAIL rand_ctl%0d: got %b want %b", i, obs_ctl, m_ctl());
      end
      checks++;
      if ({ForwardAE, ForwardBE} !== {m_fwd(Rs1E), m_fwd(Rs2E)}) begin
        errors++; $display("FAIL rand_fwd%0d: got %b want %b", i, {ForwardAE, ForwardBE},
                           {m_fwd(Rs1E), m_fwd(Rs2E)});
      end
      checks++;
      if (MemTimeout !== m_timeout || state_dbg !== m_state()) begin
        errors++; $display("FAIL rand_state%0d: got to=%b st=%0d want to=%b st=%0d",
                           i, MemTimeout, state_dbg, m_timeout, m_state());
      end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    m_init_left = STARTUP; m_wait_cnt = 0; m_timeout = 0;
    idle_inputs();
    @(negedge clk);
    #2;
    test_reset();
    test_startup("startup");
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
